// File: rtl/cpu_test_monitor_pkg.sv
// -----------------------------------------------------------------------------
// cpu_test_monitor_pkg
// Shared constants, monitor state encoding and small helpers for the CPU run
// monitor (cpu_test_monitor, check_slot, cpu_test_monitor_if).
// -----------------------------------------------------------------------------
package cpu_test_monitor_pkg;

   localparam int unsigned DATA_W     = 32;
   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned STATE_W    = 3;

   // Default tohost mailbox address; a store here ends the run
   localparam logic [DATA_W-1:0] TOHOST_ADDR_DEFAULT = 32'h0000_0FFC;

   typedef enum logic [STATE_W-1:0] {
      MON_IDLE    = 3'd0,
      MON_RUN     = 3'd1,
      MON_CHECK   = 3'd2,
      MON_PASS    = 3'd3,
      MON_FAIL    = 3'd4,
      MON_TIMEOUT = 3'd5
   } mon_state_e;

   // Increment that sticks at all-ones instead of wrapping
   function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
      return (v == '1) ? v : v + DATA_W'(1);
   endfunction

endpackage : cpu_test_monitor_pkg

// File: rtl/cpu_test_monitor_if.sv
// -----------------------------------------------------------------------------
// cpu_test_monitor_if
// Snoop and verdict bundle between a CPU (or bench) and cpu_test_monitor.
//   master : drives the writeback/memory/fetch snoop and the check table,
//            observes the verdict.
//   slave  : the monitor; observes the snoop and check table, drives verdict.
// Signals:
//   wb_en/wb_addr/wb_data          register-file writeback port
//   mem_wr_sig/mem_addr/mem_wr_data data-memory store bus
//   rom_addr                       fetch PC (halt detection builds only)
//   chk_reg/chk_val                per-slot register index / expected value
//   done/pass/timeout/fail_mask    sticky verdict
//   exit_code/cycle_count          tohost word and RUN cycle count
// -----------------------------------------------------------------------------
interface cpu_test_monitor_if #(
   parameter int unsigned NUM_CHECKS = 2
) ();
   import cpu_test_monitor_pkg::*;

   logic                             wb_en;
   logic [REG_ADDR_W-1:0]            wb_addr;
   logic [DATA_W-1:0]                wb_data;
   logic                             mem_wr_sig;
   logic [DATA_W-1:0]                mem_addr;
   logic [DATA_W-1:0]                mem_wr_data;
   logic [DATA_W-1:0]                rom_addr;
   logic [REG_ADDR_W*NUM_CHECKS-1:0] chk_reg;
   logic [DATA_W*NUM_CHECKS-1:0]     chk_val;

   logic                             done;
   logic                             pass;
   logic                             timeout;
   logic [NUM_CHECKS-1:0]            fail_mask;
   logic [DATA_W-1:0]                exit_code;
   logic [DATA_W-1:0]                cycle_count;

   modport master (
      output wb_en, wb_addr, wb_data,
      output mem_wr_sig, mem_addr, mem_wr_data,
      output rom_addr, chk_reg, chk_val,
      input  done, pass, timeout, fail_mask, exit_code, cycle_count
   );

   modport slave (
      input  wb_en, wb_addr, wb_data,
      input  mem_wr_sig, mem_addr, mem_wr_data,
      input  rom_addr, chk_reg, chk_val,
      output done, pass, timeout, fail_mask, exit_code, cycle_count
   );

endinterface : cpu_test_monitor_if

// File: rtl/cpu_test_monitor_check_slot.sv
// -----------------------------------------------------------------------------
// check_slot
// One register-compare slot: shadows a single architectural register by
// snooping the writeback port while capture_en is high, and flags a mismatch
// against the expected value.
// Ports:
//   clk, reset_n   clock, async active-low reset
//   capture_en     high while the monitor is in RUN
//   wb_en/addr/data writeback snoop
//   watch_reg      register index this slot shadows
//   expect_val     expected final value
//   mismatch_c     combinational shadow != expect_val
// -----------------------------------------------------------------------------
module check_slot
   import cpu_test_monitor_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  capture_en,
   input  logic                  wb_en,
   input  logic [REG_ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0]     wb_data,
   input  logic [REG_ADDR_W-1:0] watch_reg,
   input  logic [DATA_W-1:0]     expect_val,
   output logic                  mismatch_c
);

   logic [DATA_W-1:0] shadow_q;
   logic              hit_c;

   // x0 is hard-wired zero, so writes to it never reach the shadow
   assign hit_c = capture_en && wb_en && (wb_addr == watch_reg) && (wb_addr != '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shadow_q <= '0;
      end else if (hit_c) begin
         shadow_q <= wb_data;
      end
   end

   assign mismatch_c = (shadow_q != expect_val);

endmodule : check_slot

// File: rtl/cpu_test_monitor.sv
// -----------------------------------------------------------------------------
// cpu_test_monitor
// Synthesisable end-of-program monitor for the CPU benches and FPGA demo.
// Snoops register writeback and the data-memory bus, detects end of program
// (tohost store, timeout, or optionally a PC halt), compares shadowed
// registers with expected values and holds a sticky verdict until reset.
//
// Build option: define HALT_DETECT_EN to also end the run when rom_addr holds
// still for HALT_CYCLES consecutive samples (programs ending in jal x0,0).
//
// Parameters:
//   NUM_CHECKS     number of compare slots (1..8)
//   TIMEOUT_CYCLES RUN cycles before a TIMEOUT verdict (>= 2)
//   TOHOST_ADDR    store address that ends the run
//   HALT_CYCLES    PC-stable samples counted as a halt (HALT_DETECT_EN only)
// Ports:
//   clk, reset_n   clock, async active-low reset
//   mon            cpu_test_monitor_if slave: snoop inputs, verdict outputs
// -----------------------------------------------------------------------------
module cpu_test_monitor
   import cpu_test_monitor_pkg::*;
#(
   parameter int unsigned       NUM_CHECKS     = 2,
   parameter int unsigned       TIMEOUT_CYCLES = 500,
   parameter logic [DATA_W-1:0] TOHOST_ADDR    = TOHOST_ADDR_DEFAULT
`ifdef HALT_DETECT_EN
   ,
   parameter int unsigned       HALT_CYCLES    = 8
`endif
) (
   input  logic              clk,
   input  logic              reset_n,
   cpu_test_monitor_if.slave mon
);

   mon_state_e state_q, state_d;

   logic                  done_q;
   logic                  pass_q;
   logic                  timeout_q;
   logic [NUM_CHECKS-1:0] fail_mask_q;
   logic [DATA_W-1:0]     exit_code_q;
   logic [DATA_W-1:0]     cycle_count_q;

   logic                  tohost_c;
   logic                  halt_c;
   logic                  timeout_hit_c;
   logic                  capture_en_c;
   logic [NUM_CHECKS-1:0] mismatch_c;

   // FSM-driven strobes into the output registers
   logic                  count_en_c;
   logic                  exit_load_c;
   logic [DATA_W-1:0]     exit_val_c;
   logic                  verdict_set_c;
   logic                  timeout_set_c;

   assign tohost_c      = mon.mem_wr_sig && (mon.mem_addr == TOHOST_ADDR);
   assign timeout_hit_c = (cycle_count_q == DATA_W'(TIMEOUT_CYCLES - 1));
   assign capture_en_c  = (state_q == MON_RUN);

   // Compare slots, one per checked register
   for (genvar i = 0; i < NUM_CHECKS; i++) begin : g_slot
      check_slot u_slot (
         .clk        (clk),
         .reset_n    (reset_n),
         .capture_en (capture_en_c),
         .wb_en      (mon.wb_en),
         .wb_addr    (mon.wb_addr),
         .wb_data    (mon.wb_data),
         .watch_reg  (mon.chk_reg[i*REG_ADDR_W +: REG_ADDR_W]),
         .expect_val (mon.chk_val[i*DATA_W +: DATA_W]),
         .mismatch_c (mismatch_c[i])
      );
   end

`ifdef HALT_DETECT_EN
   localparam int unsigned HC_W = $clog2(HALT_CYCLES + 1);

   logic [DATA_W-1:0] pc_q;
   logic [HC_W-1:0]   stable_q;
   logic              pc_same_c;

   assign pc_same_c = (mon.rom_addr == pc_q);

   // Counts consecutive unchanged fetch PCs while running
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc_q     <= '0;
         stable_q <= '0;
      end else begin
         pc_q <= mon.rom_addr;
         if ((state_q != MON_RUN) || !pc_same_c) begin
            stable_q <= '0;
         end else if (stable_q != HC_W'(HALT_CYCLES)) begin
            stable_q <= stable_q + HC_W'(1);
         end
      end
   end

   // Fires on the HALT_CYCLES-th consecutive equal sample
   assign halt_c = (state_q == MON_RUN) && pc_same_c &&
                   (stable_q == HC_W'(HALT_CYCLES - 1));
`else
   assign halt_c = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= MON_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and output-register strobes; tohost outranks halt and timeout
   always_comb begin
      state_d       = state_q;
      count_en_c    = 1'b0;
      exit_load_c   = 1'b0;
      exit_val_c    = '0;
      verdict_set_c = 1'b0;
      timeout_set_c = 1'b0;

      unique case (state_q)
         MON_IDLE: begin
            state_d = MON_RUN;
         end
         MON_RUN: begin
            count_en_c = 1'b1;
            if (tohost_c) begin
               state_d     = MON_CHECK;
               exit_load_c = 1'b1;
               exit_val_c  = mon.mem_wr_data;
            end else if (halt_c) begin
               state_d     = MON_CHECK;
               exit_load_c = 1'b1;
            end else if (timeout_hit_c) begin
               state_d       = MON_TIMEOUT;
               timeout_set_c = 1'b1;
            end
         end
         MON_CHECK: begin
            verdict_set_c = 1'b1;
            if ((mismatch_c == '0) && (exit_code_q == '0)) begin
               state_d = MON_PASS;
            end else begin
               state_d = MON_FAIL;
            end
         end
         MON_PASS, MON_FAIL, MON_TIMEOUT: begin
            state_d = state_q;
         end
         default: begin
            state_d = MON_IDLE;
         end
      endcase
   end

   // Verdict, exit code and cycle counter registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         done_q        <= 1'b0;
         pass_q        <= 1'b0;
         timeout_q     <= 1'b0;
         fail_mask_q   <= '0;
         exit_code_q   <= '0;
         cycle_count_q <= '0;
      end else begin
         if (count_en_c) begin
            cycle_count_q <= sat_inc(cycle_count_q);
         end
         if (exit_load_c) begin
            exit_code_q <= exit_val_c;
         end
         if (verdict_set_c) begin
            done_q      <= 1'b1;
            pass_q      <= (state_d == MON_PASS);
            fail_mask_q <= mismatch_c;
         end
         if (timeout_set_c) begin
            done_q      <= 1'b1;
            timeout_q   <= 1'b1;
            pass_q      <= 1'b0;
            fail_mask_q <= mismatch_c;
         end
      end
   end

   assign mon.done        = done_q;
   assign mon.pass        = pass_q;
   assign mon.timeout     = timeout_q;
   assign mon.fail_mask   = fail_mask_q;
   assign mon.exit_code   = exit_code_q;
   assign mon.cycle_count = cycle_count_q;

endmodule : cpu_test_monitor

// File: tb/tb_cpu_test_monitor.sv
// -----------------------------------------------------------------------------
// tb_cpu_test_monitor
// Self-checking bench for cpu_test_monitor: each scenario pushes its expected
// verdict to a scoreboard queue; the verdict is popped and compared once the
// monitor reports done.
// -----------------------------------------------------------------------------
module tb_cpu_test_monitor;
   import cpu_test_monitor_pkg::*;

   localparam int unsigned NC     = 2;
   localparam int unsigned TO     = 500;
   localparam logic [31:0] TOHOST = 32'h0000_0FFC;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;

   always #5 clk = ~clk;

   cpu_test_monitor_if #(.NUM_CHECKS(NC)) mon ();

   cpu_test_monitor #(
      .NUM_CHECKS     (NC),
      .TIMEOUT_CYCLES (TO),
      .TOHOST_ADDR    (TOHOST)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .mon     (mon.slave)
   );

   typedef struct {
      string       name;
      logic        pass_v;
      logic        timeout_v;
      logic [31:0] mask_v;
      logic [31:0] exit_v;
      logic [31:0] cycles_v;
      bit          chk_cycles;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   pc_advance = 1'b1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
   task automatic step();
      @(posedge clk);
      #1;
      if (pc_advance) mon.rom_addr = mon.rom_addr + 32'd4;
   endtask

   task automatic idle_bus();
      mon.wb_en       = 1'b0;
      mon.wb_addr     = '0;
      mon.wb_data     = '0;
      mon.mem_wr_sig  = 1'b0;
      mon.mem_addr    = '0;
      mon.mem_wr_data = '0;
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_done"},    32'(mon.done),      32'd0);
      check({tag, "_pass"},    32'(mon.pass),      32'd0);
      check({tag, "_timeout"}, 32'(mon.timeout),   32'd0);
      check({tag, "_mask"},    32'(mon.fail_mask), 32'd0);
      check({tag, "_exit"},    mon.exit_code,      32'd0);
      check({tag, "_cycles"},  mon.cycle_count,    32'd0);
   endtask

   // Reset, load the check table, release: returns in the first RUN cycle
   task automatic start_run(input logic [4:0] r0, input logic [31:0] v0,
                            input logic [4:0] r1, input logic [31:0] v1);
      idle_bus();
      #1 reset_n = 1'b0;
      mon.chk_reg = {r1, r0};
      mon.chk_val = {v1, v0};
      #1;
      check_cleared("reset");
      step();
      reset_n = 1'b1;
      step();
   endtask

   task automatic wb(input logic [4:0] a, input logic [31:0] d);
      mon.wb_en   = 1'b1;
      mon.wb_addr = a;
      mon.wb_data = d;
      step();
      idle_bus();
   endtask

   // Tohost store (optionally with a same-cycle writeback), then two more edges
   task automatic store(input logic [31:0] code, input bit with_wb,
                        input logic [4:0] a, input logic [31:0] d);
      mon.mem_wr_sig  = 1'b1;
      mon.mem_addr    = TOHOST;
      mon.mem_wr_data = code;
      if (with_wb) begin
         mon.wb_en   = 1'b1;
         mon.wb_addr = a;
         mon.wb_data = d;
      end
      step();
      idle_bus();
      step();
      step();
   endtask

   task automatic push_exp(input string name, input logic p, input logic t,
                           input logic [31:0] m, input logic [31:0] e,
                           input logic [31:0] c, input bit cc);
      exp_t x;
      x.name = name; x.pass_v = p; x.timeout_v = t; x.mask_v = m;
      x.exit_v = e; x.cycles_v = c; x.chk_cycles = cc;
      sb_q.push_back(x);
   endtask

   // Wait (bounded) for done, then pop and compare the expected verdict
   task automatic score(input int bound);
      exp_t e;
      int   waited = 0;
      while (!mon.done && waited < bound) begin
         step();
         waited++;
      end
      if (sb_q.size() == 0) begin
         check("scoreboard_empty", 32'd0, 32'd1);
      end else begin
         e = sb_q.pop_front();
         check({e.name, "_done"},    32'(mon.done),      32'd1);
         check({e.name, "_pass"},    32'(mon.pass),      32'(e.pass_v));
         check({e.name, "_timeout"}, 32'(mon.timeout),   32'(e.timeout_v));
         check({e.name, "_mask"},    32'(mon.fail_mask), e.mask_v);
         check({e.name, "_exit"},    mon.exit_code,      e.exit_v);
         if (e.chk_cycles) check({e.name, "_cycles"}, mon.cycle_count, e.cycles_v);
      end
   endtask

   initial begin
      idle_bus();
      mon.rom_addr = 32'h0;
      mon.chk_reg  = '0;
      mon.chk_val  = '0;

      // Writebacks 21,34,55 to x3 and an ignored x0 write; slot1 watches x0
      start_run(5'd3, 32'd55, 5'd0, 32'd0);
      wb(5'd3, 32'd21); wb(5'd3, 32'd34); wb(5'd3, 32'd55); wb(5'd0, 32'd7);
      push_exp("pass_x3", 1'b1, 1'b0, 32'h0, 32'd0, 32'd5, 1'b1);
      store(32'd0, 1'b0, 5'd0, 32'd0);
      score(0);

      // Same program, wrong expectation on slot0
      start_run(5'd3, 32'd54, 5'd0, 32'd0);
      wb(5'd3, 32'd21); wb(5'd3, 32'd34); wb(5'd3, 32'd55); wb(5'd0, 32'd7);
      push_exp("fail_x3", 1'b0, 1'b0, 32'h1, 32'd0, 32'd5, 1'b1);
      store(32'd0, 1'b0, 5'd0, 32'd0);
      score(0);

      // All slots match but a nonzero exit code is stored
      start_run(5'd3, 32'd55, 5'd0, 32'd0);
      wb(5'd3, 32'd55);
      push_exp("exit3", 1'b0, 1'b0, 32'h0, 32'd3, 32'd2, 1'b1);
      store(32'd3, 1'b0, 5'd0, 32'd0);
      score(0);

      // Two slots watch the same register with different expectations
      start_run(5'd5, 32'd9, 5'd5, 32'd8);
      wb(5'd5, 32'd9);
      push_exp("shared_reg", 1'b0, 1'b0, 32'h2, 32'd0, 32'd2, 1'b1);
      store(32'd0, 1'b0, 5'd0, 32'd0);
      score(0);

      // Writeback in the same cycle as the tohost store
      start_run(5'd29, 32'd55, 5'd0, 32'd0);
      push_exp("same_cycle", 1'b1, 1'b0, 32'h0, 32'd0, 32'd1, 1'b1);
      store(32'd0, 1'b1, 5'd29, 32'd55);
      score(0);

      // Reset asserted mid-run clears everything, then the run restarts
      start_run(5'd29, 32'd55, 5'd0, 32'd0);
      wb(5'd29, 32'd55); wb(5'd29, 32'd1);
      check("midrun_cycles_before", mon.cycle_count, 32'd2);
      reset_n = 1'b0;
      #1;
      check_cleared("midrun_reset");
      step();
      reset_n = 1'b1;
      step();
      push_exp("after_reset", 1'b1, 1'b0, 32'h0, 32'd0, 32'd1, 1'b1);
      store(32'd0, 1'b1, 5'd29, 32'd55);
      score(0);

      // Tohost store on the same edge the timeout would fire: tohost wins
      start_run(5'd0, 32'd0, 5'd0, 32'd0);
      for (int i = 0; i < int'(TO) - 1; i++) step();
      push_exp("tohost_vs_timeout", 1'b1, 1'b0, 32'h0, 32'd0, 32'(TO), 1'b1);
      store(32'd0, 1'b0, 5'd0, 32'd0);
      score(0);

      // No store: timeout with slot0 never written (mismatch kept for diagnosis)
      start_run(5'd3, 32'd55, 5'd0, 32'd0);
      push_exp("timeout", 1'b0, 1'b1, 32'h1, 32'd0, 32'(TO), 1'b1);
      score(int'(TO) + 20);
      for (int i = 0; i < 5; i++) step();
      check("timeout_cycles_frozen", mon.cycle_count, 32'(TO));
      check("timeout_done_sticky",   32'(mon.done),   32'd1);

      // PC parked at 0x40: halt when built with halt detection, else timeout
      pc_advance   = 1'b0;
      mon.rom_addr = 32'h40;
      start_run(5'd0, 32'd0, 5'd0, 32'd0);
`ifdef HALT_DETECT_EN
      push_exp("halt", 1'b1, 1'b0, 32'h0, 32'd0, 32'd0, 1'b0);
`else
      push_exp("halt_no_detect", 1'b0, 1'b1, 32'h0, 32'd0, 32'(TO), 1'b1);
`endif
      score(int'(TO) + 20);
      pc_advance = 1'b1;

      check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_cpu_test_monitor
